// File: rtl/master_port_arb_if.sv
// Serial master line plus controller handshake for master_port_arb.
// The arbiter connects through the slave modport; the master/controller side uses the master modport.
interface master_port_arb_if #(
    parameter int S_ID_WIDTH = 2
);
    logic                  port_in;
    logic                  port_out;
    logic [1:0]            cmd;
    logic                  req;
    logic [S_ID_WIDTH-1:0] id;
    logic [1:0]            com_state;
    logic                  done;
    logic                  split_pending;
    logic                  timeout;

    modport slave (
        input  port_in, cmd,
        output port_out, req, id, com_state, done, split_pending, timeout
    );

    modport master (
        output port_in, cmd,
        input  port_out, req, id, com_state, done, split_pending, timeout
    );
endinterface

// File: rtl/master_port_arb.sv
// Per-master port arbiter: decodes a serial request frame, negotiates a grant with the
// bus controller, and relays grant, ACK, split and preempt signalling on the serial line.
module master_port_arb #(
    parameter int NO_SLAVES    = 3,
    parameter int S_ID_WIDTH   = $clog2(NO_SLAVES + 1),
    parameter int PREAMBLE_LEN = 3,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic clk,
    input  logic rst,
    master_port_arb_if.slave bus_io
);
    typedef enum logic [3:0] {
        S_IDLE, S_PREAMBLE, S_ID_SHIFT, S_WAIT_GRANT, S_SEND_GRANT,
        S_WAIT_ACK, S_COM, S_SEND_STOP, S_WAIT_DONE, S_OVER
    } state_t;

    localparam logic [1:0] CMD_CLEAR  = 2'b11;
    localparam logic [1:0] CMD_STOP_S = 2'b01;
    localparam logic [1:0] CMD_STOP_P = 2'b10;
    localparam logic [1:0] CS_END  = 2'b00;
    localparam logic [1:0] CS_NAK  = 2'b01;
    localparam logic [1:0] CS_WAIT = 2'b10;
    localparam logic [1:0] CS_COM  = 2'b11;
    localparam int CNT_W = $clog2(PREAMBLE_LEN + S_ID_WIDTH + 4);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [2:0]            rx_q, rx_d;
    logic [2:0]            tx_q, tx_d;
    logic [S_ID_WIDTH-1:0] idsr_q, idsr_d;
    logic                  port_out_q, port_out_d;
    logic                  req_q, req_d;
    logic [S_ID_WIDTH-1:0] id_q, id_d;
    logic [1:0]            cs_q, cs_d;
    logic                  done_q, done_d;
    logic                  split_q, split_d;
    logic                  timeout_q, timeout_d;

    logic [CNT_W-1:0]      cnt_inc;
    logic [S_ID_WIDTH-1:0] id_shift;
    logic [2:0]            win;

    assign cnt_inc  = cnt_q + 1'b1;
    assign id_shift = S_ID_WIDTH'({idsr_q, bus_io.port_in});
    assign win      = {rx_q[1:0], bus_io.port_in};

    // port_out_d is computed for the state being entered, so the registered line
    // lines up with the state register; tx_q holds the bits still to be sent.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        rx_d       = win;
        tx_d       = tx_q;
        idsr_d     = idsr_q;
        port_out_d = 1'b0;
        req_d      = req_q;
        id_d       = id_q;
        cs_d       = cs_q;
        done_d     = 1'b0;
        split_d    = split_q;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE, S_PREAMBLE: begin
                if (bus_io.port_in) begin
                    if (cnt_inc == CNT_W'(PREAMBLE_LEN)) begin
                        state_d = S_ID_SHIFT;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_PREAMBLE;
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            S_ID_SHIFT: begin
                idsr_d = id_shift;
                if (cnt_q == CNT_W'(S_ID_WIDTH - 1)) begin
                    cnt_d = '0;
                    if (id_shift != '0 && int'(id_shift) <= NO_SLAVES) begin
                        id_d    = id_shift;
                        req_d   = 1'b1;
                        state_d = S_WAIT_GRANT;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_GRANT: begin
                if (bus_io.cmd == CMD_CLEAR) begin
                    req_d      = 1'b0;
                    state_d    = S_SEND_GRANT;
                    port_out_d = 1'b1;
                    tx_d       = {~split_q, 2'b00};
                    cnt_d      = '0;
                end
            end
            S_SEND_GRANT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_WAIT_ACK;
                    split_d = 1'b0;
                    cs_d    = CS_WAIT;
                    rx_d    = 3'b000;
                    tmr_d   = '0;
                    cnt_d   = '0;
                end else begin
                    port_out_d = tx_q[2];
                    tx_d       = {tx_q[1:0], 1'b0};
                    cnt_d      = cnt_inc;
                end
            end
            S_WAIT_ACK: begin
                if (win == 3'b101) begin
                    state_d    = S_COM;
                    cs_d       = CS_COM;
                    port_out_d = 1'b1;
                    // Preset to 1s so the end-of-frame 01 needs a real 0 from the master.
                    rx_d       = 3'b111;
                end else if (win == 3'b110) begin
                    state_d = S_OVER;
                    cs_d    = CS_NAK;
                end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    state_d   = S_OVER;
                    cs_d      = CS_NAK;
                    timeout_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_COM: begin
                if (win[1:0] == 2'b01) begin
                    state_d = S_OVER;
                    cs_d    = CS_END;
                end else if (bus_io.cmd == CMD_STOP_S) begin
                    split_d = 1'b1;
                    tx_d    = 3'b100;
                    state_d = S_SEND_STOP;
                    cnt_d   = '0;
                end else if (bus_io.cmd == CMD_STOP_P) begin
                    tx_d    = 3'b000;
                    state_d = S_SEND_STOP;
                    cnt_d   = '0;
                end else begin
                    port_out_d = 1'b1;
                end
            end
            S_SEND_STOP: begin
                if (cnt_q == CNT_W'(3)) begin
                    state_d = S_WAIT_DONE;
                    rx_d    = 3'b111;
                    cnt_d   = '0;
                end else begin
                    port_out_d = tx_q[2];
                    tx_d       = {tx_q[1:0], 1'b0};
                    cnt_d      = cnt_inc;
                end
            end
            S_WAIT_DONE: begin
                if (win == 3'b010) begin
                    done_d  = 1'b1;
                    req_d   = 1'b1;
                    state_d = S_WAIT_GRANT;
                end
            end
            S_OVER: begin
                state_d = S_IDLE;
                cs_d    = CS_END;
                split_d = 1'b0;
                id_d    = '0;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tmr_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            idsr_q     <= '0;
            port_out_q <= 1'b0;
            req_q      <= 1'b0;
            id_q       <= '0;
            cs_q       <= CS_END;
            done_q     <= 1'b0;
            split_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            idsr_q     <= idsr_d;
            port_out_q <= port_out_d;
            req_q      <= req_d;
            id_q       <= id_d;
            cs_q       <= cs_d;
            done_q     <= done_d;
            split_q    <= split_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus_io.port_out      = port_out_q;
    assign bus_io.req           = req_q;
    assign bus_io.id            = id_q;
    assign bus_io.com_state     = cs_q;
    assign bus_io.done          = done_q;
    assign bus_io.split_pending = split_q;
    assign bus_io.timeout       = timeout_q;
endmodule

// File: tb/tb_master_port_arb.sv
// Scoreboard bench for master_port_arb: stimulus queues the per-cycle expected outputs,
// a negedge monitor pops and compares them against the interface.
module tb_master_port_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    master_port_arb_if #(.S_ID_WIDTH(2)) bus();

    master_port_arb #(
        .NO_SLAVES(3), .S_ID_WIDTH(2), .PREAMBLE_LEN(3), .ACK_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .bus_io(bus)
    );

    typedef struct packed {
        logic       po;
        logic       req;
        logic [1:0] id;
        logic [1:0] cs;
        logic       done;
        logic       sp;
        logic       to;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    localparam logic [1:0] NONE = 2'b00, CLEAR = 2'b11, STOP_S = 2'b01, STOP_P = 2'b10;
    localparam logic [1:0] C_END = 2'b00, C_NAK = 2'b01, C_WA = 2'b10, C_COM = 2'b11;
    localparam obs_t Z = '0;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    function automatic obs_t O(input logic po, input logic req, input logic [1:0] idv,
                               input logic [1:0] cs, input logic done, input logic sp,
                               input logic to);
        return {po, req, idv, cs, done, sp, to};
    endfunction

    function automatic obs_t sample();
        return {bus.port_out, bus.req, bus.id, bus.com_state, bus.done,
                bus.split_pending, bus.timeout};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("po=%b req=%b id=%0d cs=%b done=%b sp=%b to=%b",
                         o.po, o.req, o.id, o.cs, o.done, o.sp, o.to);
    endfunction

    task automatic check(input string tag, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %s, required %s", tag, fmt(act), fmt(exp));
        end
    endtask

    // Drive one cycle of inputs and queue the outputs required after the next edge.
    task automatic step(input logic pin, input logic [1:0] c, input obs_t e, input string tag);
        bus.port_in = pin;
        bus.cmd     = c;
        @(posedge clk);
        sb.push_back('{e, tag});
        #1;
    endtask

    task automatic frame(input logic [1:0] idv);
        step(1'b1, NONE, Z, "pre0");
        step(1'b1, NONE, Z, "pre1");
        step(1'b1, NONE, Z, "pre2");
        step(idv[1], NONE, Z, "id_msb");
        step(idv[0], NONE, (idv != 2'b00) ? O(0, 1, idv, C_END, 0, 0, 0) : Z, "id_lsb");
    endtask

    task automatic grant(input logic [1:0] idv, input logic sp, input logic [1:0] cs_prev);
        step(1'b0, CLEAR, O(1, 0, idv, cs_prev, 0, sp, 0), "grant_msb");
        step(1'b0, NONE, O(!sp, 0, idv, cs_prev, 0, sp, 0), "grant_lsb");
        step(1'b0, NONE, O(0, 0, idv, C_WA, 0, 0, 0), "wait_ack");
    endtask

    task automatic ack(input logic [1:0] idv);
        step(1'b1, NONE, O(0, 0, idv, C_WA, 0, 0, 0), "ack1");
        step(1'b0, NONE, O(0, 0, idv, C_WA, 0, 0, 0), "ack0");
        step(1'b1, NONE, O(1, 0, idv, C_COM, 0, 0, 0), "ack_com");
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t x;
                x = sb.pop_front();
                check(x.tag, sample(), x.v);
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.port_in = 1'b0;
        bus.cmd = NONE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", sample(), Z);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic grant, ACK, master end-of-frame.
        frame(2'b10);
        step(1'b0, NONE, O(0, 1, 2'd2, C_END, 0, 0, 0), "wg_hold");
        grant(2'd2, 1'b0, C_END);
        ack(2'd2);
        step(1'b0, NONE, O(1, 0, 2'd2, C_COM, 0, 0, 0), "com");
        step(1'b1, NONE, O(0, 0, 2'd2, C_END, 0, 0, 0), "eof");
        step(1'b0, NONE, Z, "over");

        // Reserved ID 0 is dropped.
        frame(2'b00);
        step(1'b0, NONE, Z, "id0_idle");

        // Broken preamble, then boundary ID 3; stops ignored before grant; ACK timeout.
        step(1'b1, NONE, Z, "brk1");
        step(1'b1, NONE, Z, "brk2");
        step(1'b0, NONE, Z, "brk0");
        frame(2'b11);
        step(1'b0, STOP_S, O(0, 1, 2'd3, C_END, 0, 0, 0), "wg_ign_s");
        step(1'b0, STOP_P, O(0, 1, 2'd3, C_END, 0, 0, 0), "wg_ign_p");
        grant(2'd3, 1'b0, C_END);
        repeat (15) step(1'b0, NONE, O(0, 0, 2'd3, C_WA, 0, 0, 0), "ack_wait");
        step(1'b0, NONE, O(0, 0, 2'd3, C_NAK, 0, 0, 1), "timeout");
        step(1'b0, NONE, Z, "to_over");

        // Split, resume grant 10, then NAK.
        frame(2'b01);
        grant(2'd1, 1'b0, C_END);
        ack(2'd1);
        step(1'b0, STOP_S, O(0, 0, 2'd1, C_COM, 0, 1, 0), "stop_s");
        step(1'b0, NONE, O(1, 0, 2'd1, C_COM, 0, 1, 0), "ss1");
        step(1'b0, NONE, O(0, 0, 2'd1, C_COM, 0, 1, 0), "ss2");
        step(1'b0, NONE, O(0, 0, 2'd1, C_COM, 0, 1, 0), "ss3");
        step(1'b0, NONE, O(0, 0, 2'd1, C_COM, 0, 1, 0), "wd_enter");
        step(1'b0, NONE, O(0, 0, 2'd1, C_COM, 0, 1, 0), "wd0");
        step(1'b1, NONE, O(0, 0, 2'd1, C_COM, 0, 1, 0), "wd1");
        step(1'b0, NONE, O(0, 1, 2'd1, C_COM, 1, 1, 0), "done");
        step(1'b0, NONE, O(0, 1, 2'd1, C_COM, 0, 1, 0), "wg_resume");
        grant(2'd1, 1'b1, C_COM);
        step(1'b1, NONE, O(0, 0, 2'd1, C_WA, 0, 0, 0), "nak1");
        step(1'b1, NONE, O(0, 0, 2'd1, C_WA, 0, 0, 0), "nak2");
        step(1'b0, NONE, O(0, 0, 2'd1, C_NAK, 0, 0, 0), "nak");
        step(1'b0, NONE, Z, "nak_over");

        // End-of-frame beats a simultaneous STOP_P.
        frame(2'b10);
        grant(2'd2, 1'b0, C_END);
        ack(2'd2);
        step(1'b0, NONE, O(1, 0, 2'd2, C_COM, 0, 0, 0), "com2");
        step(1'b1, STOP_P, O(0, 0, 2'd2, C_END, 0, 0, 0), "eof_wins");
        step(1'b0, NONE, Z, "eof_over");
        step(1'b0, NONE, Z, "eof_idle");

        // Asynchronous reset in the middle of SEND_STOP.
        frame(2'b11);
        grant(2'd3, 1'b0, C_END);
        ack(2'd3);
        step(1'b0, STOP_S, O(0, 0, 2'd3, C_COM, 0, 1, 0), "stop_s2");
        step(1'b0, NONE, O(1, 0, 2'd3, C_COM, 0, 1, 0), "ss_bit1");
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("rst_async", sample(), Z);
        step(1'b1, NONE, Z, "in_rst0");
        step(1'b1, NONE, Z, "in_rst1");
        rst = 1'b0;
        frame(2'b01);
        step(1'b0, NONE, O(0, 1, 2'd1, C_END, 0, 0, 0), "resume_wg");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
